// File: rtl/peak_pkg.sv
// peak_pkg
//   Shared types and parameter defaults for the peak/trough counter.
//   state_t : detector FSM state encoding (SEEK, RISING, FALLING)
//   *_DEF   : default values for the top-level parameters
package peak_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } state_t;

  localparam int W_DEF       = 10;
  localparam int CNT_W_DEF   = 10;
  localparam int IVL_W_DEF   = 16;
  localparam int MIN_GAP_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   clk   : clock
//   reset : synchronous active-high reset, q -> 0
//   clr   : synchronous clear; if inc is also high, q -> 1 (this cycle's
//           count is kept, which is how the gap counter reloads to 1)
//   inc   : increment by one, holding at all-ones
//   q     : count value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? WIDTH'(1) : '0;
    end else if (inc && !(&q)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/peak_trough_counter.sv
// peak_trough_counter
//   Hysteresis peak/trough detector with saturating event counters and an
//   inter-peak interval measurement.
//   clk, reset     : clock, synchronous active-high reset
//   sample_valid   : qualifies sample; nothing advances when low
//   sample, hyst   : unsigned sample and hysteresis threshold
//   clear          : zeroes counters and interval/value outputs
//   peak_pulse     : one-cycle strobe per counted peak
//   trough_pulse   : one-cycle strobe per counted trough
//   num_peaks      : saturating peak count
//   num_troughs    : saturating trough count
//   peak_value     : extreme value of the last counted peak
//   last_interval  : valid samples between the last two counted peaks
//   interval_valid : two peaks counted since reset/clear
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   SEEK    | no direction yet; max_v/min_v bracket the samples seen
//   RISING  | climbing; max_v holds the running maximum
//   FALLING | descending; min_v holds the running minimum
module peak_trough_counter
  import peak_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IVL_W   = IVL_W_DEF,
  parameter int MIN_GAP = MIN_GAP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [W-1:0]     sample,
  input  logic [W-1:0]     hyst,
  input  logic             clear,
  output logic             peak_pulse,
  output logic             trough_pulse,
  output logic [CNT_W-1:0] num_peaks,
  output logic [CNT_W-1:0] num_troughs,
  output logic [W-1:0]     peak_value,
  output logic [IVL_W-1:0] last_interval,
  output logic             interval_valid
);

  state_t         state;
  logic [W-1:0]   max_v;
  logic [W-1:0]   min_v;
  logic           have_first;
  logic           prior_peak;
  logic [IVL_W-1:0] gap_q;

  logic [W-1:0]   thr;
  logic [W:0]     rise_d;
  logic [W:0]     fall_d;
  logic           rise_ok;
  logic           fall_ok;
  logic           peak_det;
  logic           peak_cnt;
  logic           trough_det;

  // A zero threshold is treated as one so that a repeated sample is never
  // mistaken for a reversal; any real step still counts.
  assign thr = (hyst == '0) ? W'(1) : hyst;

  // Differences carry a borrow bit: a set MSB means the step went the
  // other way and can never satisfy the threshold.
  assign rise_d  = {1'b0, sample} - {1'b0, min_v};
  assign fall_d  = {1'b0, max_v} - {1'b0, sample};
  assign rise_ok = !rise_d[W] && (rise_d[W-1:0] >= thr);
  assign fall_ok = !fall_d[W] && (fall_d[W-1:0] >= thr);

  assign peak_det   = sample_valid && (state == RISING) && fall_ok;
  assign trough_det = sample_valid && (state == FALLING) && rise_ok;
  // The first peak after reset/clear has no reference, so it is always taken.
  assign peak_cnt   = peak_det && (!prior_peak || (gap_q >= IVL_W'(MIN_GAP)));

  sat_counter #(.WIDTH(IVL_W)) u_gap (
    .clk   (clk),
    .reset (reset),
    .clr   (peak_cnt),
    .inc   (sample_valid),
    .q     (gap_q)
  );

  sat_counter #(.WIDTH(CNT_W)) u_peaks (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (peak_cnt && !clear),
    .q     (num_peaks)
  );

  sat_counter #(.WIDTH(CNT_W)) u_troughs (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (trough_det && !clear),
    .q     (num_troughs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= SEEK;
      max_v          <= '0;
      min_v          <= '0;
      have_first     <= 1'b0;
      prior_peak     <= 1'b0;
      peak_pulse     <= 1'b0;
      trough_pulse   <= 1'b0;
      peak_value     <= '0;
      last_interval  <= '0;
      interval_valid <= 1'b0;
    end else begin
      peak_pulse   <= peak_cnt;
      trough_pulse <= trough_det;

      if (sample_valid) begin
        case (state)
          SEEK: begin
            if (!have_first) begin
              max_v      <= sample;
              min_v      <= sample;
              have_first <= 1'b1;
            end else if (rise_ok) begin
              state <= RISING;
              max_v <= sample;
            end else if (fall_ok) begin
              state <= FALLING;
              min_v <= sample;
            end else begin
              if (sample > max_v) max_v <= sample;
              if (sample < min_v) min_v <= sample;
            end
          end
          RISING: begin
            if (fall_ok) begin
              state <= FALLING;
              min_v <= sample;
            end else if (sample > max_v) begin
              max_v <= sample;
            end
          end
          FALLING: begin
            if (rise_ok) begin
              state <= RISING;
              max_v <= sample;
            end else if (sample < min_v) begin
              min_v <= sample;
            end
          end
          default: state <= SEEK;
        endcase
      end

      if (clear) begin
        peak_value     <= '0;
        last_interval  <= '0;
        interval_valid <= 1'b0;
        prior_peak     <= 1'b0;
      end else if (peak_cnt) begin
        peak_value    <= max_v;
        last_interval <= gap_q;
        prior_peak    <= 1'b1;
        if (prior_peak) interval_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_peak_trough_counter.sv
// tb_peak_trough_counter
//   Directed bench for peak_trough_counter (CNT_W=3 to reach saturation).
module tb_peak_trough_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [9:0] sample;
  logic [9:0] hyst;
  logic       clear;
  logic       peak_pulse;
  logic       trough_pulse;
  logic [2:0] num_peaks;
  logic [2:0] num_troughs;
  logic [9:0] peak_value;
  logic [15:0] last_interval;
  logic       interval_valid;

  int checks   = 0;
  int failures = 0;

  peak_trough_counter #(
    .W       (10),
    .CNT_W   (3),
    .IVL_W   (16),
    .MIN_GAP (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .sample         (sample),
    .hyst           (hyst),
    .clear          (clear),
    .peak_pulse     (peak_pulse),
    .trough_pulse   (trough_pulse),
    .num_peaks      (num_peaks),
    .num_troughs    (num_troughs),
    .peak_value     (peak_value),
    .last_interval  (last_interval),
    .interval_valid (interval_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit v, input int s, input bit clr);
    @(negedge clk);
    sample_valid = v;
    sample       = 10'(s);
    clear        = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input string tag, input int s, input bit clr,
                      input bit ep, input bit et);
    step(1'b1, s, clr);
    chk({tag, " peak_pulse"}, int'(peak_pulse), int'(ep));
    chk({tag, " trough_pulse"}, int'(trough_pulse), int'(et));
  endtask

  // Reset is applied with a valid sample that would otherwise cause a trough.
  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample       = 10'd100;
    clear        = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset        = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " peak_pulse"},     int'(peak_pulse),     0);
    chk({tag, " trough_pulse"},   int'(trough_pulse),   0);
    chk({tag, " num_peaks"},      int'(num_peaks),      0);
    chk({tag, " num_troughs"},    int'(num_troughs),    0);
    chk({tag, " peak_value"},     int'(peak_value),     0);
    chk({tag, " last_interval"},  int'(last_interval),  0);
    chk({tag, " interval_valid"}, int'(interval_valid), 0);
  endtask

  function automatic int tri10(input int i);
    int p;
    p = i % 10;
    return (p <= 5) ? p * 10 : (10 - p) * 10;
  endfunction

  function automatic int tri20(input int i);
    int p;
    p = i % 20;
    return (p <= 10) ? p * 10 : (20 - p) * 10;
  endfunction

  initial begin
    int s035[9];
    int s036[5];
    int s0[7];
    int s040[9];
    int pk_seen;

    s035 = '{0, 10, 20, 30, 20, 10, 0, 10, 20};
    s036 = '{100, 104, 99, 103, 100};
    s0   = '{5, 5, 6, 6, 5, 5, 6};
    s040 = '{0, 10, 20, 30, 40, 30, 20, 10, 0};

    reset        = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    hyst         = 10'd8;
    clear        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // Clean swing: peak after the 20 on descent, trough after the 10 on ascent.
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        step(1'b0, 0, 1'b0);
        chk("invalid peak_pulse", int'(peak_pulse), 0);
      end
      feed("swing", s035[i], 1'b0, (i == 4), (i == 7));
    end
    chk("swing num_peaks",      int'(num_peaks),      1);
    chk("swing num_troughs",    int'(num_troughs),    1);
    chk("swing peak_value",     int'(peak_value),     30);
    chk("swing interval_valid", int'(interval_valid), 0);

    // Sub-threshold noise.
    do_reset();
    for (int i = 0; i < 5; i++) feed("noise", s036[i], 1'b0, 1'b0, 1'b0);
    chk("noise num_peaks",   int'(num_peaks),   0);
    chk("noise num_troughs", int'(num_troughs), 0);

    // Zero hysteresis: ties are not reversals.
    do_reset();
    hyst = 10'd0;
    for (int i = 0; i < 7; i++) feed("hyst0", s0[i], 1'b0, (i == 4), (i == 6));
    chk("hyst0 num_peaks",  int'(num_peaks),  1);
    chk("hyst0 peak_value", int'(peak_value), 6);
    hyst = 10'd8;

    // Period-10 triangle with MIN_GAP 16: only every other peak counts.
    do_reset();
    for (int i = 0; i < 50; i++)
      feed("tri10", tri10(i), 1'b0, (i == 6 || i == 26 || i == 46),
           (i >= 11 && i % 10 == 1));
    chk("tri10 num_peaks",      int'(num_peaks),      3);
    chk("tri10 num_troughs",    int'(num_troughs),    4);
    chk("tri10 last_interval",  int'(last_interval),  20);
    chk("tri10 interval_valid", int'(interval_valid), 1);
    chk("tri10 peak_value",     int'(peak_value),     50);

    // Clear on the cycle of a counted peak, then the next peak has no prior.
    for (int i = 50; i < 77; i++) begin
      feed("clr", tri10(i), (i == 66), (i == 66 || i == 76), (i % 10 == 1));
      if (i == 66) begin
        chk("clr@pk num_peaks",      int'(num_peaks),      0);
        chk("clr@pk num_troughs",    int'(num_troughs),    0);
        chk("clr@pk interval_valid", int'(interval_valid), 0);
        chk("clr@pk peak_value",     int'(peak_value),     0);
        chk("clr@pk last_interval",  int'(last_interval),  0);
      end
    end
    chk("postclr num_peaks",      int'(num_peaks),      1);
    chk("postclr num_troughs",    int'(num_troughs),    1);
    chk("postclr interval_valid", int'(interval_valid), 0);
    chk("postclr last_interval",  int'(last_interval),  10);
    chk("postclr peak_value",     int'(peak_value),     50);

    // Reset wins over a valid sample and clears everything.
    do_reset();
    chk_zero("rst");

    // Reset mid-RISING discards the 200 extreme.
    for (int i = 0; i < 4; i++) begin
      int r;
      r = (i == 0) ? 0 : (i == 1) ? 10 : (i == 2) ? 100 : 200;
      feed("prerst", r, 1'b0, 1'b0, 1'b0);
    end
    do_reset();
    for (int i = 0; i < 9; i++) feed("rstrise", s040[i], 1'b0, (i == 5), 1'b0);
    chk("rstrise num_peaks",  int'(num_peaks),  1);
    chk("rstrise peak_value", int'(peak_value), 40);

    // Nine well-spaced peaks saturate the 3-bit counter at 7.
    do_reset();
    pk_seen = 0;
    for (int i = 0; i < 180; i++) begin
      bit ep;
      ep = (i >= 11) && ((i - 11) % 20 == 0);
      feed("sat", tri20(i), 1'b0, ep, (i >= 21) && (i % 20 == 1));
      if (ep) begin
        pk_seen++;
        chk("sat num_peaks", int'(num_peaks), (pk_seen > 7) ? 7 : pk_seen);
      end
    end
    chk("sat final num_peaks", int'(num_peaks), 7);
    chk("sat peak_value",      int'(peak_value), 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peak_trough_counter.md
PEAK_TROUGH_COUNTER -- requirements
Module: peak_trough_counter

Interface
REQ-001 Parameter W, default 10: sample width, unsigned.
REQ-002 Parameter CNT_W, default 10: width of peak/trough counters.
REQ-003 Parameter IVL_W, default 16: width of inter-peak interval counter.
REQ-004 Parameter MIN_GAP, default 16: minimum valid samples between two counted peaks.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sample_valid  in  1  qualifies sample; FSM advances only on valid cycles.
REQ-008 sample  in  W  filtered signal sample, unsigned.
REQ-009 hyst  in  W  hysteresis threshold, sampled on each valid cycle.
REQ-010 clear  in  1  synchronous clear of counters and interval outputs.
REQ-011 peak_pulse  out  1  one-cycle strobe per counted peak.
REQ-012 trough_pulse  out  1  one-cycle strobe per counted trough.
REQ-013 num_peaks  out  CNT_W  saturating peak count.
REQ-014 num_troughs  out  CNT_W  saturating trough count.
REQ-015 peak_value  out  W  extreme value of last counted peak.
REQ-016 last_interval  out  IVL_W  valid samples between last two counted peaks.
REQ-017 interval_valid  out  1  high once two peaks have been counted since reset/clear.

Function
REQ-018 FSM states SEEK, RISING, FALLING; tracking registers max_v, min_v; all comparisons unsigned, differences in W+1 bits.
REQ-019 SEEK: first valid sample loads max_v=min_v=sample; later: sample-min_v >= hyst -> RISING (max_v=sample); min_v-sample... i.e. max_v-sample >= hyst -> FALLING (min_v=sample); otherwise widen max_v/min_v.
REQ-020 RISING: sample > max_v updates max_v (ties do not update); max_v-sample >= hyst -> peak event, FALLING, min_v=sample.
REQ-021 FALLING: sample < min_v updates min_v; sample-min_v >= hyst -> trough event, RISING, max_v=sample.
REQ-022 Peak event counted only if gap counter >= MIN_GAP or no peak counted yet; uncounted peak still changes state, no pulse, no output update.
REQ-023 Gap counter increments per valid sample, saturates at all-ones, reloads to 1 on counted peak.
REQ-024 Counted peak: peak_pulse=1, num_peaks+1, peak_value=max_v, last_interval=gap counter value, interval_valid set if a prior peak exists; all visible cycle after the valid sample (latency 1).
REQ-025 Counted trough: trough_pulse=1, num_troughs+1, latency 1; troughs not subject to MIN_GAP.
REQ-026 Counters saturate at 2^CNT_W-1; pulses still asserted at saturation.
REQ-027 hyst=0: every direction reversal counts; equal consecutive samples produce no event.
REQ-028 sample_valid low: state, trackers, gap counter hold; pulses low.
REQ-029 clear: num_peaks, num_troughs, last_interval, interval_valid, peak_value zeroed, "prior peak" flag cleared; FSM and trackers unaffected.
REQ-030 clear with simultaneous event: clear wins for counters/outputs (read 0), pulse still asserted.

Reset
REQ-031 reset: FSM=SEEK, trackers 0, gap counter 0, prior-peak flag 0, all outputs 0.
REQ-032 reset has priority over clear and sample_valid; mid-operation reset discards in-progress extreme.

Structure
REQ-033 Package peak_pkg holds state enum (SEEK, RISING, FALLING) and parameter defaults.
REQ-034 Sub-module sat_counter (parametrised width, inc, clr) used for num_peaks, num_troughs, gap counter.

Verification
REQ-035 hyst=8, samples 0,10,20,30,20,10,0,10,20 -> one peak (peak_value=30) pulse after sample 20 on descent, one trough after sample 10 on ascent.
REQ-036 hyst=8, noise 100,104,99,103,100 -> no pulses, counts remain 0.
REQ-037 MIN_GAP=16, triangle period 10 samples amplitude 50, hyst=8 -> every other peak counted; last_interval=20.
REQ-038 CNT_W=3, 9 clean peaks -> num_peaks stops at 7, peak_pulse on each.
REQ-039 clear asserted on cycle of peak event -> peak_pulse=1, num_peaks=0, interval_valid=0.
REQ-040 reset mid-RISING then samples 0..40 step 10, down to 0 -> first peak counted regardless of gap, peak_value=40.
